// File: rtl/pulse_width_counter_multi.sv
// pulse_width_counter_multi
//
// Measures the high time, low time and period, in CLK cycles, of CHANNELS
// independent asynchronous inputs. Each input passes through its own
// synchroniser and is measured by its own small FSM and saturating counters.
// A registered read port returns one field of one channel.
//
// Ports:
//   CLK        single clock for the whole block
//   RST_N      asynchronous active-low reset
//   FREQ_IN    raw asynchronous inputs, bit i feeds channel i
//   CLEAR      synchronous pulse: re-arm every channel, zero all results
//   SEL_CH     read channel select (values >= CHANNELS read as 0)
//   SEL_FIELD  read field: 0 PERIOD, 1 TIME_LOW, 2 TIME_HIGH, 3 STATUS
//   DATA_OUT   registered read data
//   VALID      channel has completed at least one full period since arm
//   OVF        sticky: a channel counter or period sum saturated
//   UPDATE     one-cycle strobe when a channel writes PERIOD/TIME_LOW
//
// STATUS layout: bit0 VALID, bit1 OVF, bit2 synchronised input,
// bits4:3 FSM state (0 ARM, 1 WAIT_RISE, 2 MEASURE), other bits 0.
//
// Handshake: there is none; every output is a level or a one-cycle strobe
// valid on the cycle it is registered, and reads have fixed one-cycle latency.

module pulse_width_counter_multi #(
  parameter int CHANNELS     = 4,
  parameter int COUNTER_BITS = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int SEL_BITS     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [CHANNELS-1:0]     FREQ_IN,
  input  logic                    CLEAR,
  input  logic [SEL_BITS-1:0]     SEL_CH,
  input  logic [1:0]              SEL_FIELD,
  output logic [COUNTER_BITS-1:0] DATA_OUT,
  output logic [CHANNELS-1:0]     VALID,
  output logic [CHANNELS-1:0]     OVF,
  output logic [CHANNELS-1:0]     UPDATE
);

  typedef enum logic [1:0] {
    ST_ARM       = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_MEASURE   = 2'd2
  } state_t;

  localparam logic [COUNTER_BITS-1:0] CNT_MAX = '1;

  // The synchroniser flops come out of reset at 0, so for the first few
  // cycles s reads 0 regardless of the pin. ARM must not treat that as a
  // real low, otherwise an input held high through reset would be taken
  // as a fresh rise. primed goes high once the chain holds real samples.
  logic [SYNC_STAGES-1:0] prime_q;
  logic                   primed;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) prime_q <= '0;
    else        prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign primed = prime_q[SYNC_STAGES-1];

  logic [COUNTER_BITS-1:0] period_a [CHANNELS];
  logic [COUNTER_BITS-1:0] tlow_a   [CHANNELS];
  logic [COUNTER_BITS-1:0] thigh_a  [CHANNELS];
  logic [COUNTER_BITS-1:0] status_a [CHANNELS];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    d_q;
    logic                    s;
    logic                    rise;
    logic                    fall;
    state_t                  state_q;
    state_t                  state_d;
    logic [COUNTER_BITS-1:0] hi_q;
    logic [COUNTER_BITS-1:0] lo_q;
    logic [COUNTER_BITS-1:0] th_q;
    logic [COUNTER_BITS-1:0] tl_q;
    logic [COUNTER_BITS-1:0] per_q;
    logic                    seen_fall_q;
    logic                    valid_q;
    logic                    ovf_q;
    logic                    upd_q;
    logic [COUNTER_BITS:0]   hi_sum;
    logic [COUNTER_BITS:0]   lo_sum;
    logic [COUNTER_BITS:0]   per_sum;
    logic [COUNTER_BITS-1:0] hi_inc;
    logic [COUNTER_BITS-1:0] lo_inc;
    logic [COUNTER_BITS-1:0] per_sat;
    logic [4:0]              status_raw;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~d_q;
    assign fall = ~s & d_q;

    // Sums are one bit wider so the carry marks saturation.
    assign hi_sum  = {1'b0, hi_q} + (COUNTER_BITS+1)'(1);
    assign lo_sum  = {1'b0, lo_q} + (COUNTER_BITS+1)'(1);
    assign per_sum = {1'b0, th_q} + {1'b0, lo_q};
    assign hi_inc  = hi_sum[COUNTER_BITS]  ? CNT_MAX : hi_sum[COUNTER_BITS-1:0];
    assign lo_inc  = lo_sum[COUNTER_BITS]  ? CNT_MAX : lo_sum[COUNTER_BITS-1:0];
    assign per_sat = per_sum[COUNTER_BITS] ? CNT_MAX : per_sum[COUNTER_BITS-1:0];

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        sync_q <= '0;
        d_q    <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], FREQ_IN[g]};
        d_q    <= s;
      end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= ST_ARM;
      else        state_q <= state_d;
    end

    always_comb begin
      state_d = state_q;
      case (state_q)
        ST_ARM:       if (primed && !s) state_d = ST_WAIT_RISE;
        ST_WAIT_RISE: if (rise)         state_d = ST_MEASURE;
        ST_MEASURE:                     state_d = ST_MEASURE;
        default:                        state_d = ST_ARM;
      endcase
      if (CLEAR) state_d = ST_ARM;
    end

    // Counting. The rise that leaves WAIT_RISE only starts the high count;
    // results are written on rises that follow a fall seen in MEASURE.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        hi_q        <= '0;
        lo_q        <= '0;
        th_q        <= '0;
        tl_q        <= '0;
        per_q       <= '0;
        seen_fall_q <= 1'b0;
        valid_q     <= 1'b0;
        ovf_q       <= 1'b0;
        upd_q       <= 1'b0;
      end else begin
        upd_q <= 1'b0;
        if (CLEAR) begin
          hi_q        <= '0;
          lo_q        <= '0;
          th_q        <= '0;
          tl_q        <= '0;
          per_q       <= '0;
          seen_fall_q <= 1'b0;
          valid_q     <= 1'b0;
          ovf_q       <= 1'b0;
        end else if (state_q == ST_WAIT_RISE && rise) begin
          hi_q        <= COUNTER_BITS'(1);
          seen_fall_q <= 1'b0;
        end else if (state_q == ST_MEASURE) begin
          if (rise) begin
            hi_q <= COUNTER_BITS'(1);
            if (seen_fall_q) begin
              tl_q    <= lo_q;
              per_q   <= per_sat;
              valid_q <= 1'b1;
              upd_q   <= 1'b1;
              if (per_sum[COUNTER_BITS]) ovf_q <= 1'b1;
            end
          end else if (fall) begin
            th_q        <= hi_q;
            lo_q        <= COUNTER_BITS'(1);
            seen_fall_q <= 1'b1;
          end else if (s) begin
            hi_q <= hi_inc;
            if (hi_inc == CNT_MAX) ovf_q <= 1'b1;
          end else begin
            lo_q <= lo_inc;
            if (lo_inc == CNT_MAX) ovf_q <= 1'b1;
          end
        end
      end
    end

    assign status_raw  = {state_q, s, ovf_q, valid_q};
    assign period_a[g] = per_q;
    assign tlow_a[g]   = tl_q;
    assign thigh_a[g]  = th_q;
    assign status_a[g] = COUNTER_BITS'(status_raw);
    assign VALID[g]    = valid_q;
    assign OVF[g]      = ovf_q;
    assign UPDATE[g]   = upd_q;
  end

  logic [COUNTER_BITS-1:0] rd_data;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (SEL_CH == SEL_BITS'(i)) begin
        case (SEL_FIELD)
          2'd0:    rd_data = period_a[i];
          2'd1:    rd_data = tlow_a[i];
          2'd2:    rd_data = thigh_a[i];
          default: rd_data = status_a[i];
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) DATA_OUT <= '0;
    else        DATA_OUT <= rd_data;
  end

endmodule

// File: tb/tb_pulse_width_counter_multi.sv
// Bench for pulse_width_counter_multi. Main instance: 4 channels, 16-bit
// counters, 3-bit select. Second instance: 2 channels, 4-bit counters, used
// for saturation. Expected values come from pulse run lengths.

module tb_pulse_width_counter_multi;

  localparam int CH   = 4;
  localparam int CB   = 16;
  localparam int SB   = 3;
  localparam int CH_B = 2;
  localparam int CB_B = 4;
  localparam int SB_B = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [CH-1:0]   freq_in;
  logic            clear;
  logic [SB-1:0]   sel_ch;
  logic [1:0]      sel_field;
  logic [CB-1:0]   data_out;
  logic [CH-1:0]   valid;
  logic [CH-1:0]   ovf;
  logic [CH-1:0]   update;

  logic [CH_B-1:0] freq_b;
  logic            clear_b;
  logic [SB_B-1:0] sel_ch_b;
  logic [1:0]      sel_field_b;
  logic [CB_B-1:0] data_b;
  logic [CH_B-1:0] valid_b;
  logic [CH_B-1:0] ovf_b;
  logic [CH_B-1:0] update_b;

  pulse_width_counter_multi #(
    .CHANNELS(CH), .COUNTER_BITS(CB), .SYNC_STAGES(2), .SEL_BITS(SB)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .FREQ_IN(freq_in), .CLEAR(clear),
    .SEL_CH(sel_ch), .SEL_FIELD(sel_field), .DATA_OUT(data_out),
    .VALID(valid), .OVF(ovf), .UPDATE(update)
  );

  pulse_width_counter_multi #(
    .CHANNELS(CH_B), .COUNTER_BITS(CB_B), .SYNC_STAGES(2), .SEL_BITS(SB_B)
  ) dut_b (
    .CLK(clk), .RST_N(rst_n), .FREQ_IN(freq_b), .CLEAR(clear_b),
    .SEL_CH(sel_ch_b), .SEL_FIELD(sel_field_b), .DATA_OUT(data_b),
    .VALID(valid_b), .OVF(ovf_b), .UPDATE(update_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  // UPDATE monitor: cumulative pulse count and spacing per channel.
  int cyc = 0;
  int upd_cnt  [CH];
  int upd_last [CH];
  int upd_gap  [CH];

  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < CH; i++) begin
      if (update[i] === 1'b1) begin
        upd_cnt[i] = upd_cnt[i] + 1;
        upd_gap[i] = cyc - upd_last[i];
        upd_last[i] = cyc;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end just after a falling edge.
  task automatic hold(input logic [CH-1:0] v, input int n);
    freq_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic read_a(input int ch, input int f, output logic [CB-1:0] d);
    sel_ch    = SB'(ch);
    sel_field = 2'(f);
    @(negedge clk);
    d = data_out;
  endtask

  task automatic read_b(input int ch, input int f, output logic [CB_B-1:0] d);
    sel_ch_b    = SB_B'(ch);
    sel_field_b = 2'(f);
    @(negedge clk);
    d = data_b;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [CB-1:0] rd;
    rst_n = 1'b0;
    freq_in = 4'b0001; clear = 1'b0; sel_ch = '0; sel_field = 2'd0;
    freq_b = '0; clear_b = 1'b0; sel_ch_b = '0; sel_field_b = 2'd0;
    #12;
    n_cmp++; if (data_out !== 16'd0) begin n_err++; $display("FAIL reset_data: got %0d want 0", data_out); end
    n_cmp++; if (valid !== 4'd0) begin n_err++; $display("FAIL reset_valid: got %b want 0000", valid); end
    n_cmp++; if (ovf !== 4'd0) begin n_err++; $display("FAIL reset_ovf: got %b want 0000", ovf); end
    n_cmp++; if (update !== 4'd0) begin n_err++; $display("FAIL reset_update: got %b want 0000", update); end
    @(negedge clk);
    rst_n = 1'b1;
    hold(4'b0001, 10);
    n_cmp++; if (upd_cnt[0] !== 0) begin n_err++; $display("FAIL reset_high_upd: got %0d want 0", upd_cnt[0]); end
    n_cmp++; if (valid[0] !== 1'b0) begin n_err++; $display("FAIL reset_high_valid: got %b want 0", valid[0]); end
    read_a(0, 3, rd);
    n_cmp++; if (rd !== 16'd4) begin n_err++; $display("FAIL reset_high_status_arm: got %0d want 4", rd); end
    hold(4'b0000, 4);
    hold(4'b0001, 5);
    read_a(0, 3, rd);
    n_cmp++; if (rd !== 16'd20) begin n_err++; $display("FAIL reset_status_measure: got %0d want 20", rd); end
    n_cmp++; if (valid[0] !== 1'b0) begin n_err++; $display("FAIL reset_after_rise_valid: got %b want 0", valid[0]); end
  endtask

  task automatic test_square();
    logic [CB-1:0] rd;
    int u0;
    hold(4'b0000, 4);
    pulse_clear();
    hold(4'b0000, 4);
    u0 = upd_cnt[0];
    for (int k = 0; k < 6; k++) begin
      hold(4'b0001, 3);
      hold(4'b0000, 5);
    end
    n_cmp++; if (upd_cnt[0] - u0 !== 5) begin n_err++; $display("FAIL square_upd_count: got %0d want 5", upd_cnt[0] - u0); end
    n_cmp++; if (upd_gap[0] !== 8) begin n_err++; $display("FAIL square_upd_gap: got %0d want 8", upd_gap[0]); end
    n_cmp++; if (valid[0] !== 1'b1) begin n_err++; $display("FAIL square_valid: got %b want 1", valid[0]); end
    n_cmp++; if (ovf[0] !== 1'b0) begin n_err++; $display("FAIL square_ovf: got %b want 0", ovf[0]); end
    read_a(0, 0, rd);
    n_cmp++; if (rd !== 16'd8) begin n_err++; $display("FAIL square_period: got %0d want 8", rd); end
    read_a(0, 1, rd);
    n_cmp++; if (rd !== 16'd5) begin n_err++; $display("FAIL square_tlow: got %0d want 5", rd); end
    read_a(0, 2, rd);
    n_cmp++; if (rd !== 16'd3) begin n_err++; $display("FAIL square_thigh: got %0d want 3", rd); end
  endtask

  task automatic test_saturation();
    logic [CB_B-1:0] rd;
    freq_b = 2'b00;
    repeat (4) @(negedge clk);
    freq_b = 2'b01; repeat (20) @(negedge clk);
    freq_b = 2'b00; repeat (2) @(negedge clk);
    // High for 4 + 3 read cycles = 7.
    freq_b = 2'b01; repeat (4) @(negedge clk);
    read_b(0, 2, rd);
    n_cmp++; if (rd !== 4'd15) begin n_err++; $display("FAIL sat_thigh: got %0d want 15", rd); end
    read_b(0, 1, rd);
    n_cmp++; if (rd !== 4'd2) begin n_err++; $display("FAIL sat_tlow: got %0d want 2", rd); end
    read_b(0, 0, rd);
    n_cmp++; if (rd !== 4'd15) begin n_err++; $display("FAIL sat_period: got %0d want 15", rd); end
    n_cmp++; if (ovf_b !== 2'b01) begin n_err++; $display("FAIL sat_ovf: got %b want 01", ovf_b); end
    freq_b = 2'b00; repeat (4) @(negedge clk);
    freq_b = 2'b01; repeat (4) @(negedge clk);
    read_b(0, 2, rd);
    n_cmp++; if (rd !== 4'd7) begin n_err++; $display("FAIL sat_next_thigh: got %0d want 7", rd); end
    read_b(0, 1, rd);
    n_cmp++; if (rd !== 4'd4) begin n_err++; $display("FAIL sat_next_tlow: got %0d want 4", rd); end
    read_b(0, 0, rd);
    n_cmp++; if (rd !== 4'd11) begin n_err++; $display("FAIL sat_next_period: got %0d want 11", rd); end
    n_cmp++; if (ovf_b !== 2'b01) begin n_err++; $display("FAIL sat_ovf_sticky: got %b want 01", ovf_b); end
    n_cmp++; if (valid_b !== 2'b01) begin n_err++; $display("FAIL sat_valid: got %b want 01", valid_b); end
    freq_b = 2'b00;
  endtask

  task automatic test_multichannel();
    int per [CH];
    int c;
    int f;
    logic [CB-1:0] exp_prev;
    per[0] = 4; per[1] = 6; per[2] = 10; per[3] = 12;
    exp_prev = '0;
    hold(4'b0000, 4);
    pulse_clear();
    hold(4'b0000, 4);
    for (int t = 0; t < 100; t++) begin
      if (t == 63) begin
        n_cmp++; if (update !== 4'b1111) begin n_err++; $display("FAIL multi_simul_update: got %b want 1111", update); end
      end
      if (t >= 40) begin
        n_cmp++; if (data_out !== exp_prev) begin n_err++; $display("FAIL multi_read t=%0d: got %0d want %0d", t, data_out, exp_prev); end
      end
      for (int i = 0; i < CH; i++) freq_in[i] = ((t % per[i]) < (per[i] / 2));
      c = (t == 60) ? 5 : (t == 70) ? 4 : int'($urandom_range(0, 5));
      f = int'($urandom_range(0, 2));
      sel_ch    = SB'(c);
      sel_field = 2'(f);
      if (c >= CH)     exp_prev = '0;
      else if (f == 0) exp_prev = CB'(per[c]);
      else             exp_prev = CB'(per[c] / 2);
      @(negedge clk);
    end
    hold(4'b0000, 4);
  endtask

  task automatic test_clear_on_rise();
    logic [CB-1:0] rd;
    int u1;
    hold(4'b0000, 4);
    pulse_clear();
    hold(4'b0000, 4);
    for (int k = 0; k < 3; k++) begin
      hold(4'b0010, 3);
      hold(4'b0000, 3);
    end
    n_cmp++; if (valid[1] !== 1'b1) begin n_err++; $display("FAIL clr_pre_valid: got %b want 1", valid[1]); end
    u1 = upd_cnt[1];
    // Rise sampled on the next edge is detected two edges later, where CLEAR sits.
    freq_in = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    pulse_clear();
    hold(4'b0010, 3);
    n_cmp++; if (upd_cnt[1] !== u1) begin n_err++; $display("FAIL clr_no_update: got %0d want %0d", upd_cnt[1], u1); end
    n_cmp++; if (valid !== 4'b0000) begin n_err++; $display("FAIL clr_valid: got %b want 0000", valid); end
    n_cmp++; if (ovf !== 4'b0000) begin n_err++; $display("FAIL clr_ovf: got %b want 0000", ovf); end
    read_a(1, 0, rd);
    n_cmp++; if (rd !== 16'd0) begin n_err++; $display("FAIL clr_period: got %0d want 0", rd); end
    read_a(1, 1, rd);
    n_cmp++; if (rd !== 16'd0) begin n_err++; $display("FAIL clr_tlow: got %0d want 0", rd); end
    read_a(1, 2, rd);
    n_cmp++; if (rd !== 16'd0) begin n_err++; $display("FAIL clr_thigh: got %0d want 0", rd); end
    read_a(1, 3, rd);
    n_cmp++; if (rd !== 16'd4) begin n_err++; $display("FAIL clr_status_arm: got %0d want 4", rd); end
    hold(4'b0000, 3);
    hold(4'b0010, 3);
    hold(4'b0000, 4);
    hold(4'b0010, 4);
    n_cmp++; if (upd_cnt[1] - u1 !== 1) begin n_err++; $display("FAIL clr_resume_upd: got %0d want 1", upd_cnt[1] - u1); end
    read_a(1, 1, rd);
    n_cmp++; if (rd !== 16'd4) begin n_err++; $display("FAIL clr_resume_tlow: got %0d want 4", rd); end
    read_a(1, 0, rd);
    n_cmp++; if (rd !== 16'd7) begin n_err++; $display("FAIL clr_resume_period: got %0d want 7", rd); end
    hold(4'b0000, 4);
  endtask

  task automatic test_async_reset();
    logic [CB-1:0] rd;
    int u0;
    hold(4'b0000, 4);
    pulse_clear();
    hold(4'b0000, 4);
    for (int k = 0; k < 3; k++) begin
      hold(4'b0001, 3);
      hold(4'b0000, 5);
    end
    read_a(0, 0, rd);
    n_cmp++; if (rd !== 16'd8) begin n_err++; $display("FAIL arst_pre_period: got %0d want 8", rd); end
    hold(4'b0001, 2);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (data_out !== 16'd0) begin n_err++; $display("FAIL arst_data: got %0d want 0", data_out); end
    n_cmp++; if (valid !== 4'd0) begin n_err++; $display("FAIL arst_valid: got %b want 0000", valid); end
    n_cmp++; if (ovf !== 4'd0) begin n_err++; $display("FAIL arst_ovf: got %b want 0000", ovf); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    u0 = upd_cnt[0];
    hold(4'b0001, 5);
    hold(4'b0000, 4);
    hold(4'b0001, 3);
    hold(4'b0000, 4);
    n_cmp++; if (upd_cnt[0] !== u0) begin n_err++; $display("FAIL arst_early_upd: got %0d want %0d", upd_cnt[0], u0); end
    n_cmp++; if (valid[0] !== 1'b0) begin n_err++; $display("FAIL arst_early_valid: got %b want 0", valid[0]); end
    hold(4'b0001, 4);
    n_cmp++; if (upd_cnt[0] - u0 !== 1) begin n_err++; $display("FAIL arst_first_upd: got %0d want 1", upd_cnt[0] - u0); end
    read_a(0, 1, rd);
    n_cmp++; if (rd !== 16'd4) begin n_err++; $display("FAIL arst_tlow: got %0d want 4", rd); end
    read_a(0, 0, rd);
    n_cmp++; if (rd !== 16'd7) begin n_err++; $display("FAIL arst_period: got %0d want 7", rd); end
    read_a(0, 2, rd);
    n_cmp++; if (rd !== 16'd3) begin n_err++; $display("FAIL arst_thigh: got %0d want 3", rd); end
    hold(4'b0000, 4);
  endtask

  // Random pulse trains on all channels. Reference: from the run lengths
  // H1 L1 H2 L2 ... Hn, the last full period is H(n-1)+L(n-1), the last
  // low is L(n-1), the last completed high is Hn, and there are n-1 updates.
  task automatic test_random();
    logic [CB-1:0] exp_q[$];
    logic [CB-1:0] rd;
    logic [CH-1:0] wave_a [256];
    int hs [CH][8];
    int ls [CH][8];
    int n  [CH];
    int u  [CH];
    int t;
    int total;
    total = 0;
    for (int i = 0; i < 256; i++) wave_a[i] = '0;
    for (int ch = 0; ch < CH; ch++) begin
      n[ch] = int'($urandom_range(2, 5));
      t = 4;
      for (int k = 0; k < n[ch]; k++) begin
        hs[ch][k] = int'($urandom_range(1, 8));
        ls[ch][k] = int'($urandom_range(1, 8));
        for (int j = 0; j < hs[ch][k]; j++) begin
          wave_a[t][ch] = 1'b1;
          t++;
        end
        if (k < n[ch] - 1) t += ls[ch][k];
      end
      if (t > total) total = t;
      exp_q.push_back(CB'(hs[ch][n[ch]-1]));
      exp_q.push_back(CB'(ls[ch][n[ch]-2]));
      exp_q.push_back(CB'(hs[ch][n[ch]-2] + ls[ch][n[ch]-2]));
    end
    total += 12;
    hold(4'b0000, 4);
    pulse_clear();
    for (int ch = 0; ch < CH; ch++) u[ch] = upd_cnt[ch];
    for (int i = 0; i < total; i++) begin
      freq_in = wave_a[i];
      @(negedge clk);
    end
    for (int ch = 0; ch < CH; ch++) begin
      n_cmp++; if (upd_cnt[ch] - u[ch] !== n[ch] - 1) begin n_err++; $display("FAIL rand_upd ch%0d: got %0d want %0d", ch, upd_cnt[ch] - u[ch], n[ch] - 1); end
    end
    n_cmp++; if (valid !== 4'b1111) begin n_err++; $display("FAIL rand_valid: got %b want 1111", valid); end
    n_cmp++; if (ovf !== 4'b0000) begin n_err++; $display("FAIL rand_ovf: got %b want 0000", ovf); end
    for (int ch = 0; ch < CH; ch++) begin
      read_a(ch, 2, rd);
      n_cmp++; if (rd !== exp_q[0]) begin n_err++; $display("FAIL rand_thigh ch%0d: got %0d want %0d", ch, rd, exp_q[0]); end
      void'(exp_q.pop_front());
      read_a(ch, 1, rd);
      n_cmp++; if (rd !== exp_q[0]) begin n_err++; $display("FAIL rand_tlow ch%0d: got %0d want %0d", ch, rd, exp_q[0]); end
      void'(exp_q.pop_front());
      read_a(ch, 0, rd);
      n_cmp++; if (rd !== exp_q[0]) begin n_err++; $display("FAIL rand_period ch%0d: got %0d want %0d", ch, rd, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < CH; i++) begin
      upd_cnt[i] = 0; upd_last[i] = 0; upd_gap[i] = 0;
    end
    test_reset();
    test_square();
    test_saturation();
    test_multichannel();
    test_clear_on_rise();
    test_async_reset();
    for (int r = 0; r < 3; r++) test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_width_counter_multi.md
# pulse_width_counter_multi

Parametrised multi-channel successor to the single-channel pulse-width/frequency counter. Each of `CHANNELS` asynchronous inputs is synchronised and measured independently for high time, low time and period in `CLK` cycles. Counters are `COUNTER_BITS` wide and saturate, with sticky overflow and valid status. A registered read port selects one channel and one field for the 8-bit top-level output mux or for a wider bus.

## Interface

Parameters:
- `CHANNELS`, default 4: number of measured inputs; must be ≥1.
- `COUNTER_BITS`, default 16: width of all counters and results; must be ≥3.
- `SYNC_STAGES`, default 2: synchroniser depth per channel; must be ≥2.
- `SEL_BITS`, default `$clog2(CHANNELS)`, minimum 1: channel select width.

Ports:
- `CLK`, input, 1: single clock domain for the whole block.
- `RST_N`, input, 1: asynchronous, active-low reset.
- `FREQ_IN`, input, `CHANNELS`: raw asynchronous inputs; bit i drives channel i.
- `CLEAR`, input, 1: synchronous pulse that re-arms all channels.
- `SEL_CH`, input, `SEL_BITS`: read channel select.
- `SEL_FIELD`, input, 2: read field select. 0 = PERIOD, 1 = TIME_LOW, 2 = TIME_HIGH, 3 = STATUS.
- `DATA_OUT`, output, `COUNTER_BITS`: registered read data.
- `VALID`, output, `CHANNELS`: channel i has completed at least one full period since arm.
- `OVF`, output, `CHANNELS`: sticky flag; a channel counter saturated.
- `UPDATE`, output, `CHANNELS`: one-cycle strobe when that channel's PERIOD and TIME_LOW are written.

## Operation

- **Synchroniser:** `s_i` is `FREQ_IN[i]` after `SYNC_STAGES` flops, and `d_i` is `s_i` delayed one cycle.
  - rise = `s_i & ~d_i`; fall = `~s_i & d_i`.
- **Per-channel FSM:**
  - ARM: wait for `s_i == 0`, then go to WAIT_RISE.
  - WAIT_RISE: on rise, go to MEASURE.
  - MEASURE: stays in MEASURE until CLEAR or reset.
  - ARM guarantees that an input held high through reset never yields a partial first pulse.
- **Counting in MEASURE:**
  - On the rise cycle, `hi_cnt <= 1`. On each further high cycle, `hi_cnt <= sat(hi_cnt + 1)`.
  - On the fall cycle: `TIME_HIGH <= hi_cnt` and `lo_cnt <= 1`. On each further low cycle, `lo_cnt <= sat(lo_cnt + 1)`.
  - On a rise with a prior fall seen since entering MEASURE:
    - `TIME_LOW <= lo_cnt`;
    - `PERIOD <= sat(TIME_HIGH + lo_cnt)`;
    - `VALID[i] <= 1`; `UPDATE[i]` pulses.
  - The first rise (the transition from WAIT_RISE) writes no results.
- **Saturation:**
  - `sat()` clamps at 2^COUNTER_BITS−1. The period sum is computed COUNTER_BITS+1 wide and then clamped.
  - A counter reaching its maximum, or a clamped sum, sets `OVF[i]`. The counter holds at maximum until the next edge.
  - Results latched while saturated equal the maximum value.
- **CLEAR:**
  - Next cycle, all channels return to ARM. All results, counters, `VALID` and `OVF` become 0. `UPDATE` is 0.
  - CLEAR wins over a simultaneous edge on any channel.
- **Read port:** `DATA_OUT <= field(SEL_CH, SEL_FIELD)` every cycle.
  - STATUS field: bit0 = VALID, bit1 = OVF, bit2 = `s_i`, bits3–4 = FSM state (ARM = 0, WAIT_RISE = 1, MEASURE = 2), all other bits 0.
  - `SEL_CH ≥ CHANNELS` returns 0.

## Timing

- **Reset values:**
  - `DATA_OUT = 0`, `VALID = 0`, `OVF = 0`, `UPDATE = 0`.
  - All results and counters are 0, all FSMs are in ARM, and synchroniser and `d_i` flops are 0.
- **Edge-to-result latency:** a `FREQ_IN` level first sampled at clock edge k reaches `s_i` at edge k+SYNC_STAGES−1. The result register and `UPDATE` change at edge k+SYNC_STAGES.
- **Read latency:** `DATA_OUT` reflects select and state one cycle after they are presented. A result written at edge n is readable on `DATA_OUT` after edge n+1.
- **Minimum pulse:** a 1-cycle high or low level (post-sync) is measured as 1.
- **Channel independence:** channels are fully independent. Simultaneous edges on several channels all update in the same cycle.
- **Reset mid-measurement:** asynchronous reset discards everything. Deassertion restarts from ARM with no output glitch other than the reset values.

## Test plan

- **Reset, input high:** hold `FREQ_IN[0]=1` through reset and release.
  - Expect no `UPDATE` and `VALID[0]=0`; STATUS state stays ARM while input is high.
  - After input goes low then high, state = MEASURE.
- **Square wave, defaults:** drive channel 0 with 3 cycles high, 5 low, repeated.
  - From the second rise, expect TIME_HIGH = 3, TIME_LOW = 5, PERIOD = 8, `VALID[0]=1`.
  - `UPDATE[0]` pulses once per 8 cycles.
- **Saturation, `COUNTER_BITS=4`:** hold the input high 20 cycles, then low 2, then rise.
  - Expect TIME_HIGH = 15, TIME_LOW = 2, PERIOD = 15, `OVF[0]=1` (sticky).
  - Later in-range pulses update results while OVF stays 1.
- **Multi-channel:** drive channels 0–3 with periods 4, 6, 10, 12 (50% duty) simultaneously.
  - Sweep `SEL_CH`/`SEL_FIELD` and expect each PERIOD/TIME_HIGH with one-cycle read latency.
  - `SEL_CH=5` with `CHANNELS=4` (`SEL_BITS=3`) returns 0.
- **CLEAR coinciding with a rise on channel 1:**
  - Expect no `UPDATE`, all results 0, VALID/OVF 0, and state ARM.
  - Measurement resumes correctly after the next low-then-rise sequence.
- **Async reset mid-high-pulse:** assert `RST_N=0` asynchronously partway through a high pulse.
  - Outputs go to 0 immediately, without a clock edge.
  - After release, the first results appear only after a full low–high–low–high sequence.
